// File: rtl/gpio_pkg.sv
// Shared register map and access-size encodings for the GPIO interrupt port.
package gpio_pkg;

  // Register index, decoded from address[5:3] (8-byte aligned slots).
  typedef enum logic [2:0] {
    REG_IN      = 3'd0,
    REG_OUT     = 3'd1,
    REG_DIR     = 3'd2,
    REG_OUT_SET = 3'd3,
    REG_OUT_CLR = 3'd4,
    REG_RISE_EN = 3'd5,
    REG_FALL_EN = 3'd6,
    REG_STAT    = 3'd7
  } gpio_reg_e;

  localparam logic [1:0] SIZE_8  = 2'b00;
  localparam logic [1:0] SIZE_16 = 2'b01;
  localparam logic [1:0] SIZE_32 = 2'b10;
  localparam logic [1:0] SIZE_64 = 2'b11;

  // Bit lanes a write of the given size is allowed to touch.
  function automatic logic [63:0] size_mask(input logic [1:0] size);
    case (size)
      SIZE_8:  return 64'h0000_0000_0000_00FF;
      SIZE_16: return 64'h0000_0000_0000_FFFF;
      SIZE_32: return 64'h0000_0000_FFFF_FFFF;
      default: return 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// Per-pin two-flop synchroniser plus a third "previous" stage for edge detection.
module gpio_sync_edge #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] pins,
  output logic [WIDTH-1:0] in_val,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] prev_q;

  // All stages clear to 0, so pins held low through reset release give no edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= pins;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign in_val = sync_q;
  assign rise   = sync_q & ~prev_q;
  assign fall   = ~sync_q & prev_q;

endmodule

// File: rtl/gpio_irq_port.sv
// Memory-mapped GPIO port: per-pin direction/output, synchronised inputs and
// sticky edge status driving a level interrupt.
module gpio_irq_port
  import gpio_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  inout  wire  [63:0]           data,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [1:0]            size,
  input  logic                  chip_select,
  inout  wire  [WIDTH-1:0]      IO,
  output logic                  irq
);

  // Bus handshake: an access is valid for exactly the cycles where
  // chip_select=1 and exactly one strobe is high. A valid read drives data
  // combinationally in that cycle; a valid write commits on the rising edge
  // that samples it. There is no wait state and no back-pressure.
  logic        acc_valid;
  logic        rd_en;
  logic        wr_en;
  logic [63:0] addr_ext;
  logic [63:0] data_in;
  logic [63:0] smask;
  gpio_reg_e   reg_sel;
  logic        unused_ok;

  logic [WIDTH-1:0] wmask;
  logic [WIDTH-1:0] wbits;
  logic [WIDTH-1:0] rdata;

  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] dir_q;
  logic [WIDTH-1:0] rise_en_q;
  logic [WIDTH-1:0] fall_en_q;
  logic [WIDTH-1:0] stat_q;
  logic [WIDTH-1:0] stat_set;
  logic [WIDTH-1:0] stat_clr;

  logic [WIDTH-1:0] in_val;
  logic [WIDTH-1:0] rise_ev;
  logic [WIDTH-1:0] fall_ev;

  assign addr_ext  = 64'(address);
  assign data_in   = data;
  assign reg_sel   = gpio_reg_e'(addr_ext[5:3]);
  assign unused_ok = ^{addr_ext, data_in};

  assign acc_valid = chip_select & (mem_read ^ mem_write);
  // The bus stays released while reset is held, even for a valid read.
  assign rd_en     = acc_valid & mem_read & reset;
  assign wr_en     = acc_valid & mem_write;

  // Slicing to WIDTH bits also confines the write to existing pins.
  assign smask = size_mask(size);
  assign wmask = smask[WIDTH-1:0];
  assign wbits = wmask & data_in[WIDTH-1:0];

  assign stat_set = (rise_ev & rise_en_q) | (fall_ev & fall_en_q);
  assign stat_clr = (wr_en && reg_sel == REG_STAT) ? wbits : '0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_q     <= '0;
      dir_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      stat_q    <= '0;
    end else begin
      if (wr_en) begin
        case (reg_sel)
          REG_OUT:     out_q     <= (out_q & ~wmask) | wbits;
          REG_DIR:     dir_q     <= (dir_q & ~wmask) | wbits;
          REG_OUT_SET: out_q     <= out_q | wbits;
          REG_OUT_CLR: out_q     <= out_q & ~wbits;
          REG_RISE_EN: rise_en_q <= (rise_en_q & ~wmask) | wbits;
          REG_FALL_EN: fall_en_q <= (fall_en_q & ~wmask) | wbits;
          default:     ;
        endcase
      end
      // Set is applied after clear so a coincident edge event wins.
      stat_q <= (stat_q & ~stat_clr) | stat_set;
    end
  end

  always_comb begin
    rdata = '0;
    case (reg_sel)
      REG_IN:      rdata = in_val;
      REG_OUT:     rdata = out_q;
      REG_DIR:     rdata = dir_q;
      REG_RISE_EN: rdata = rise_en_q;
      REG_FALL_EN: rdata = fall_en_q;
      REG_STAT:    rdata = stat_q;
      default:     rdata = '0;
    endcase
  end

  assign data = rd_en ? 64'(rdata) : 64'bz;

  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    assign IO[i] = dir_q[i] ? out_q[i] : 1'bz;
  end

  gpio_sync_edge #(
    .WIDTH(WIDTH)
  ) u_sync_edge (
    .clock (clock),
    .reset (reset),
    .pins  (IO),
    .in_val(in_val),
    .rise  (rise_ev),
    .fall  (fall_ev)
  );

  assign irq = |stat_q;

endmodule

// File: tb/tb_gpio_irq_port.sv
// Randomised scoreboard bench for gpio_irq_port with a cycle-level pin-history model.
module tb_gpio_irq_port;
  import gpio_pkg::*;

  localparam int W = 16;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  // ---------------- DUT (WIDTH=16) ----------------
  wire  [63:0] data;
  wire  [W-1:0] io;
  logic [7:0]  address = '0;
  logic        mem_read = 1'b0, mem_write = 1'b0, chip_select = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        irq;
  logic [63:0] tb_data = '0;
  logic        tb_data_en = 1'b0;
  logic [W-1:0] tb_io = '0;
  logic [W-1:0] tb_io_en = '1;

  assign data = tb_data_en ? tb_data : 64'bz;
  for (genvar i = 0; i < W; i++) begin : g_tb_pin
    assign io[i] = tb_io_en[i] ? tb_io[i] : 1'bz;
  end

  gpio_irq_port #(.WIDTH(W), .ADDR_WIDTH(8)) dut (
    .clock(clock), .reset(reset), .data(data), .address(address),
    .mem_read(mem_read), .mem_write(mem_write), .size(size),
    .chip_select(chip_select), .IO(io), .irq(irq)
  );

  // ---------------- DUT (WIDTH=64), read-only use ----------------
  wire  [63:0] data64;
  wire  [63:0] io64;
  logic [63:0] io64_drv = '0;
  logic        rd64 = 1'b0;
  logic        irq64;
  assign io64 = io64_drv;

  gpio_irq_port #(.WIDTH(64), .ADDR_WIDTH(8)) dut64 (
    .clock(clock), .reset(reset), .data(data64), .address(8'h00),
    .mem_read(rd64), .mem_write(1'b0), .size(SIZE_64),
    .chip_select(1'b1), .IO(io64), .irq(irq64)
  );

  // ---------------- reference model ----------------
  logic [W-1:0] out_m, dir_m, rise_m, fall_m, stat_m;
  logic [W-1:0] hist[$];   // hist[0] = pin value sampled at the latest edge

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  string       name_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] mask_of(input logic [1:0] sz);
    int bits;
    logic [63:0] m;
    bits = 8 << sz;
    m = (bits >= 64) ? '1 : ((64'd1 << bits) - 64'd1);
    return m[W-1:0];
  endfunction

  function automatic logic [63:0] model_read(input logic [2:0] r);
    case (r)
      3'd0:    return 64'(hist[1]);
      3'd1:    return 64'(out_m);
      3'd2:    return 64'(dir_m);
      3'd5:    return 64'(rise_m);
      3'd6:    return 64'(fall_m);
      3'd7:    return 64'(stat_m);
      default: return 64'd0;
    endcase
  endfunction

  task automatic model_reset();
    out_m = '0; dir_m = '0; rise_m = '0; fall_m = '0; stat_m = '0;
    hist = '{};
    repeat (4) hist.push_back('0);
    tb_io_en = '1;
  endtask

  // One clock: snapshot inputs, take the edge, advance the model, return at negedge.
  task automatic step();
    logic rst_s, wr_s;
    logic [2:0] r_s;
    logic [W-1:0] pins, b, m, set_ev, clr;
    logic [63:0] d_s;
    logic [1:0] sz_s;
    rst_s = reset;
    wr_s  = chip_select && (mem_read != mem_write) && mem_write;
    r_s   = address[5:3];
    d_s   = tb_data;
    sz_s  = size;
    pins  = (dir_m & out_m) | (~dir_m & tb_io);
    @(posedge clock);
    if (rst_s) begin
      hist.push_front(pins);
      set_ev = (hist[2] & ~hist[3] & rise_m) | (~hist[2] & hist[3] & fall_m);
      void'(hist.pop_back());
      clr = '0;
      if (wr_s) begin
        m = mask_of(sz_s);
        b = d_s[W-1:0] & m;
        case (r_s)
          3'd1: out_m  = (out_m & ~m) | b;
          3'd2: dir_m  = (dir_m & ~m) | b;
          3'd3: out_m  = out_m | b;
          3'd4: out_m  = out_m & ~b;
          3'd5: rise_m = (rise_m & ~m) | b;
          3'd6: fall_m = (fall_m & ~m) | b;
          3'd7: clr    = b;
          default: ;
        endcase
      end
      stat_m = (stat_m & ~clr) | set_ev;
      #1 tb_io_en = ~dir_m;
    end
    @(negedge clock);
  endtask

  // ---------------- driver tasks ----------------
  task automatic issue(input bit cs, input bit rd, input bit wr, input logic [2:0] r,
                       input logic [1:0] sz, input logic [63:0] d, input string name);
    chip_select = cs; mem_read = rd; mem_write = wr;
    address = {2'b00, r, 3'b000}; size = sz; tb_data = d; tb_data_en = wr;
    if (cs && rd && !wr) begin
      exp_q.push_back(model_read(r));
      name_q.push_back(name);
    end
    if (cs && rd && wr) begin
      #1 check("rw_conflict_data_released", data, d);
    end
    step();
    chip_select = 1'b0; mem_read = 1'b0; mem_write = 1'b0; tb_data_en = 1'b0;
    check("irq", 64'(irq), 64'(|stat_m));
  endtask

  task automatic wr_reg(input logic [2:0] r, input logic [1:0] sz, input logic [63:0] d);
    issue(1'b1, 1'b0, 1'b1, r, sz, d, "");
  endtask

  task automatic rd_reg(input logic [2:0] r, input string name);
    issue(1'b1, 1'b1, 1'b0, r, 2'($urandom_range(0, 3)), 64'd0, name);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) issue(1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 64'd0, "");
  endtask

  // Released pins are checked by driving both polarities from the bench.
  task automatic check_io();
    #1;
    check("io_driven", 64'(io & dir_m), 64'(out_m & dir_m));
    check("io_released", 64'(io & ~dir_m), 64'(tb_io & ~dir_m));
    tb_io = tb_io ^ ~dir_m;
    #1;
    check("io_released_inv", 64'(io & ~dir_m), 64'(tb_io & ~dir_m));
    tb_io = tb_io ^ ~dir_m;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clock) begin
    #4;
    if (chip_select && mem_read && !mem_write && reset) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL read_unexpected: got %h expected no read", data);
      end else begin
        check(name_q.pop_front(), data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [63:0] v64;
    model_reset();
    repeat (3) step();
    check("reset_irq", 64'(irq), 64'd0);
    check_io();
    reset = 1'b1;

    // No spurious edges after reset with pins low, even with all edges enabled.
    wr_reg(3'd5, SIZE_16, 64'hFFFF);
    wr_reg(3'd6, SIZE_16, 64'hFFFF);
    idle(3);
    rd_reg(3'd7, "stat_after_reset");
    wr_reg(3'd5, SIZE_16, 64'h0);
    wr_reg(3'd6, SIZE_16, 64'h0);

    // Direction split drives low byte, releases high byte.
    wr_reg(3'd2, SIZE_16, 64'h00FF);
    wr_reg(3'd1, SIZE_16, 64'hA5A5);
    idle(1);
    check("io_low_byte", 64'(io[7:0]), 64'hA5);
    check_io();
    rd_reg(3'd2, "dir_readback");

    // Byte write, set and clear on OUT.
    wr_reg(3'd1, SIZE_16, 64'hFFFF);
    wr_reg(3'd1, SIZE_8, 64'h3C);
    rd_reg(3'd1, "out_byte_write");
    wr_reg(3'd3, SIZE_16, 64'h0100);
    rd_reg(3'd1, "out_set");
    wr_reg(3'd4, SIZE_16, 64'hF000);
    rd_reg(3'd1, "out_clr");
    rd_reg(3'd3, "out_set_reads_zero");
    rd_reg(3'd4, "out_clr_reads_zero");

    // Rising-edge latency on bit 0; falling edge must not set STAT.
    wr_reg(3'd2, SIZE_16, 64'h0);
    tb_io = '0;
    wr_reg(3'd5, SIZE_16, 64'h0001);
    wr_reg(3'd6, SIZE_16, 64'h0);
    idle(4);
    wr_reg(3'd7, SIZE_16, 64'hFFFF);
    rd_reg(3'd7, "stat_cleared");
    tb_io[0] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      check("irq_latency", 64'(irq), 64'(c >= 3));
      rd_reg(3'd0, "in_latency");
    end
    tb_io[0] = 1'b0;
    idle(4);
    rd_reg(3'd7, "stat_after_fall");

    // Clear racing a new set on the same bit.
    wr_reg(3'd5, SIZE_16, 64'h0003);
    tb_io[1] = 1'b1;
    idle(4);
    rd_reg(3'd7, "stat_two_bits");
    tb_io[0] = 1'b1;
    idle(2);
    wr_reg(3'd7, SIZE_16, 64'h0001);
    rd_reg(3'd7, "stat_set_wins");
    wr_reg(3'd7, SIZE_16, 64'h0003);
    rd_reg(3'd7, "stat_all_cleared");
    check("irq_after_clear", 64'(irq), 64'd0);

    // Invalid accesses change nothing.
    issue(1'b1, 1'b1, 1'b1, 3'd1, SIZE_16, 64'h1234, "");
    issue(1'b0, 1'b0, 1'b1, 3'd2, SIZE_16, 64'hFFFF, "");
    for (int r = 0; r < 8; r++) rd_reg(3'(r), "after_invalid");

    // Randomised traffic.
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: wr_reg(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                           {$urandom, $urandom});
        4, 5, 6:    rd_reg(3'($urandom_range(0, 7)), "rand_read");
        7:          begin tb_io = W'($urandom); idle(1); end
        8:          idle(1);
        default:    issue(1'($urandom_range(0, 1)), 1'b1, 1'b1, 3'($urandom_range(0, 7)),
                          2'($urandom_range(0, 3)), {$urandom, $urandom}, "");
      endcase
      if (n % 16 == 0) check_io();
    end

    // Reset in the middle of a write, with every pin driven and irq high.
    wr_reg(3'd5, SIZE_16, 64'hFFFF);
    wr_reg(3'd2, SIZE_16, 64'hFFFF);
    wr_reg(3'd1, SIZE_16, 64'h00FF);
    idle(4);
    check("irq_before_reset", 64'(irq), 64'd1);
    tb_io = W'($urandom);
    chip_select = 1'b1; mem_write = 1'b1; address = {2'b00, 3'd6, 3'b000};
    tb_data = 64'h1234; tb_data_en = 1'b1;
    #2 reset = 1'b0;
    model_reset();
    #1;
    check("reset_irq_async", 64'(irq), 64'd0);
    check("reset_io_released", 64'(io), 64'(tb_io));
    mem_write = 1'b0; mem_read = 1'b1; tb_data = 64'h5A5A_0F0F_A5A5_F0F0;
    #1 check("reset_data_released", data, 64'h5A5A_0F0F_A5A5_F0F0);
    chip_select = 1'b0; mem_read = 1'b0; tb_data_en = 1'b0;
    step();
    step();
    reset = 1'b1;
    for (int r = 0; r < 8; r++) rd_reg(3'(r), "after_reset");

    // Full 64-bit IN read on the wide instance.
    for (int k = 0; k < 4; k++) begin
      v64 = (k == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
      io64_drv = v64;
      step();
      step();
      rd64 = 1'b1;
      #1 check("in64_full_width", data64, v64);
      rd64 = 1'b0;
    end
    check("irq64_idle", 64'(irq64), 64'd0);

    idle(2);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpio_irq_port.md
GPIO_IRQ_PORT -- requirements
Module: gpio_irq_port

Interface
REQ-001 SHALL have parameter WIDTH, default 16, number of IO pins (legal range 1..64).
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, number of local address bits decoded.
REQ-003 SHALL have port clock, input, 1, the single clock; all flops are rising-edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port data, inout, 64, the bidirectional system databus.
REQ-006 SHALL have port address, input, ADDR_WIDTH, the local register address.
REQ-007 SHALL have ports mem_read and mem_write, input, 1 each, the bus strobes.
REQ-008 SHALL have port size, input, 2, the access size: 00 = 8, 01 = 16, 10 = 32, 11 = 64 bits.
REQ-009 SHALL have port chip_select, input, 1, the block select from the upstream address decode.
REQ-010 SHALL have port IO, inout, WIDTH, the pins.
REQ-011 SHALL have port irq, output, 1, the level interrupt request.

Function
REQ-012 SHALL decode registers on address[5:3] (8-byte aligned): 0 IN (RO), 1 OUT (RW), 2 DIR (RW), 3 OUT_SET (WO), 4 OUT_CLR (WO), 5 RISE_EN (RW), 6 FALL_EN (RW), 7 STAT (RW, write-1-to-clear).
REQ-013 SHALL treat an access as valid only when chip_select=1 and exactly one of mem_read/mem_write is 1; otherwise the access has no effect and data is not driven.
REQ-014 SHALL drive data on a valid read combinationally, zero-extended from WIDTH to 64 bits; WO registers read 0; data is Z otherwise.
REQ-015 SHALL apply a write only to bit positions below 8/16/32/64 (per size) and below WIDTH; all other bits are retained.
REQ-016 SHALL update written registers on the clock edge that samples the valid write.
REQ-017 SHALL make an OUT_SET write OR masked data into OUT and an OUT_CLR write clear OUT bits where masked data=1.
REQ-018 SHALL drive IO[i] from OUT[i] when DIR[i]=1 and release it to Z when DIR[i]=0, per bit.
REQ-019 SHALL pass every IO bit through a 2-flop synchroniser; IN is the second stage, so a pin change is visible in IN 2 clocks later.
REQ-020 SHALL hold a third stage (previous IN); rising edge = IN & ~prev, falling edge = ~IN & prev, evaluated on all bits regardless of DIR.
REQ-021 SHALL set STAT[i] on the clock edge after IN[i] changes (3 clocks after the pin change) if the edge type is enabled in RISE_EN[i]/FALL_EN[i].
REQ-022 SHALL clear STAT[i] on a STAT write with masked data[i]=1; a simultaneous set event on the same bit wins and STAT[i] stays 1.
REQ-023 SHALL drive irq = OR of all STAT bits, from flops only (no combinational path from IO or data).
REQ-024 SHALL leave STAT bits that are already set unaffected when RISE_EN/FALL_EN change.

Reset
REQ-025 SHALL asynchronously clear OUT, DIR, RISE_EN, FALL_EN, STAT and all synchroniser/edge stages while reset=0.
REQ-026 SHALL hold all IO at Z, irq=0 and data at Z during reset.
REQ-027 SHALL NOT detect a spurious edge on the first cycles after reset release for pins held at 0; pins held at 1 MAY produce a rising event only if RISE_EN was written before the pin settles.

Structure
REQ-028 SHALL take register offsets (IN..STAT) and size encodings from shared package gpio_pkg.
REQ-029 SHALL place the per-bit synchroniser and edge detector in one sub-module, gpio_sync_edge, parameterised by WIDTH.

Verification
REQ-030 SHALL verify that WIDTH=16, a 16-bit write of DIR=0x00FF then OUT=0xA5A5 drives IO[7:0]=0xA5 and IO[15:8]=Z.
REQ-031 SHALL verify that an 8-bit write of OUT=0x3C over OUT=0xFFFF gives 0xFF3C, that OUT_SET with 0x0100 gives 0xFF3C|0x0100 (0xFF3C, unchanged), and that OUT_CLR with 0xF000 gives 0x0F3C.
REQ-032 SHALL verify that with RISE_EN=0x0001 and IO[0] driven 0->1 at cycle 0, IN[0]=1 at cycle 2, STAT=0x0001 and irq=1 at cycle 3, and that a falling edge leaves STAT unchanged.
REQ-033 SHALL verify that with STAT=0x0003, a write of 0x0001 to STAT in the same cycle as a new bit-0 edge event leaves STAT=0x0003, and that a later write of 0x0003 gives STAT=0 and irq=0.
REQ-034 SHALL verify that asserting reset mid-write with DIR=0xFFFF gives all registers 0, IO all Z and irq=0 immediately, without waiting for a clock.
REQ-035 SHALL verify that mem_read=mem_write=1 with chip_select=1 leaves data at Z and all registers unchanged, and that WIDTH=64 with a 64-bit read of IN returns the full pin value.
